cmd_parser: RTL and testbench
=============================

# cmd_parser

Parametrised command parser for the logic analyser control path. It consumes bytes from the UART receiver and decodes framed, checksummed commands into configuration registers for the sampler and trigger blocks. Sampling-rate and pattern widths are configurable, and the trigger gains a pattern mask. Configuration outputs change atomically, and only when a complete packet passes its checksum. Malformed or stalled packets are dropped and flagged.

## Interface
- `PATTERN_W`, default 8: trigger pattern/mask width, 1..32. `PB = ceil(PATTERN_W/8)` payload bytes per pattern field. `PLW = $clog2(PATTERN_W+1)`.
- `RATE_W`, default 8: sampling-rate width, 1..32. `RB = ceil(RATE_W/8)` payload bytes.
- `TIMEOUT`, default 1000000: idle clock cycles allowed between bytes inside a packet, ≥2.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_data_fresh` in 1: level, high while `rx_data` holds a new byte.
- `sampling_rate` out RATE_W: committed rate divider.
- `trigger_edge` out 1: 1 = rising, 0 = falling.
- `threshold` out 8: analog trigger threshold.
- `pattern_len` out PLW: number of relevant pattern bits.
- `pattern` out PATTERN_W: trigger pattern.
- `pattern_mask` out PATTERN_W: 1 = bit participates in match.
- `configuration_valid` out 1: high when parser is IDLE.
- `cfg_update` out 1: one-cycle pulse on commit.
- `cmd_error` out 1: one-cycle pulse on a dropped packet.
- `err_code` out 2: 1 = checksum, 2 = unknown command, 3 = timeout. Held until the next error.

## Operation
- Byte acceptance: a byte is accepted on an edge where `rx_data_fresh=1` and the internal `consumed` flag is 0. `consumed` is then set. It clears on the first edge with `rx_data_fresh=0`. Exactly one byte is accepted per high episode of `rx_data_fresh`.
- Packet format: `CMD`, payload (little-endian, first byte least significant), `CHK`. `CHK` = XOR of `CMD` and all payload bytes.
- Commands:
  - `0x17` SET_RATE: RB bytes. Upper unused bits of the last byte are ignored.
  - `0x18` SET_TRIGGER, in order:
    - edge byte (bit0 used)
    - threshold byte
    - pattern_len byte, saturated to `PATTERN_W` if larger
    - pattern, PB bytes
    - mask, PB bytes
  - `0x1A` RESET_CFG: no payload. Restores reset values.
- Decoded fields go to shadow registers. Outputs load from shadow only on a good checksum. A bad packet never disturbs the outputs.
- States:
  - IDLE: the byte is a CMD. A known code latches the command, clears `byte_idx` and the running XOR, and moves to PAYLOAD (or CHECK for 0x1A). An unknown code pulses `cmd_error` with `err_code=2` and stays in IDLE.
  - PAYLOAD: store the byte at `byte_idx` and increment. After the last payload byte, go to CHECK.
  - CHECK: if the byte matches the running XOR, commit and pulse `cfg_update`. Otherwise pulse `cmd_error` with `err_code=1`. In both cases return to IDLE.
- Timeout: a gap counter resets on each accepted byte and increments every cycle while not IDLE. When it reaches `TIMEOUT`, go to IDLE and pulse `cmd_error` with `err_code=3`. If a byte and the timeout land on the same edge, the byte wins and the counter resets.
- `rst` mid-packet: shadow data is discarded and the state returns to IDLE immediately.

## Timing
- Reset values:
  - `sampling_rate=1`, `trigger_edge=0`, `threshold=0x80`
  - `pattern_len=0`, `pattern=0`, `pattern_mask=0`
  - `configuration_valid=1`, `cfg_update=0`, `cmd_error=0`, `err_code=0`
  - `consumed=0`, state IDLE
- Commit latency: configuration outputs, `cfg_update=1` and `configuration_valid=1` all become visible after the edge that accepts `CHK`. `cfg_update` deasserts on the next edge.
- `configuration_valid` drops after the edge that accepts a known CMD.
- `cmd_error` is asserted for exactly one cycle after the detecting edge.
- All outputs are registered. There is no combinational path from `rx_data` to any output.
- Throughput: one byte per `rx_data_fresh` low→high cycle. Minimum spacing is 2 clocks.

## Test plan
Bench settings: PATTERN_W=8, RATE_W=16, TIMEOUT=100.
1. Send `17 34 12 31` → `sampling_rate=0x1234`, one `cfg_update` pulse, no `cmd_error`.
2. Send `18 01 40 05 A5 0F F6` → `trigger_edge=1`, `threshold=0x40`, `pattern_len=5`, `pattern=0xA5`, `pattern_mask=0x0F`.
3. Send the scenario-2 packet with `CHK=00` → all outputs unchanged, `cmd_error` pulse, `err_code=1`. Then send `1A 1A` → reset values restored.
4. Send `55`, then `17 34 12 31` → first byte gives `err_code=2` with `configuration_valid` staying high; rate becomes 0x1234.
5. Two sub-cases:
   - Send `17 34`, stall 100 cycles → `err_code=3`, `configuration_valid=1`, rate unchanged.
   - A byte arriving on cycle 99 extends the packet.
6. Three sub-cases:
   - Hold `rx_data_fresh` high 10 cycles → one byte accepted.
   - Send pattern_len `0x0C` → saturates to 8.
   - Assert `rst` after `18 01` → reset values, IDLE.

Source files
------------

// File: rtl/cmd_parser.sv
// cmd_parser: decodes framed, XOR-checksummed command packets from a UART byte
// stream into sampler/trigger configuration registers. Outputs only change on
// a packet whose checksum matches; anything malformed or stalled is dropped.
module cmd_parser #(
  parameter int PATTERN_W = 8,
  parameter int RATE_W    = 8,
  parameter int TIMEOUT   = 1000000,
  localparam int PB  = (PATTERN_W + 7) / 8,
  localparam int RB  = (RATE_W + 7) / 8,
  localparam int PLW = $clog2(PATTERN_W + 1),
  localparam int GW  = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_fresh,
  output logic [RATE_W-1:0]    sampling_rate,
  output logic                 trigger_edge,
  output logic [7:0]           threshold,
  output logic [PLW-1:0]       pattern_len,
  output logic [PATTERN_W-1:0] pattern,
  output logic [PATTERN_W-1:0] pattern_mask,
  output logic                 configuration_valid,
  output logic                 cfg_update,
  output logic                 cmd_error,
  output logic [1:0]           err_code
);

  // byte index only has to reach the longest payload (3 + 2*4 bytes)
  localparam int IW = 5;
  localparam logic [IW-1:0] RATE_LAST = IW'(RB - 1);
  localparam logic [IW-1:0] TRIG_LAST = IW'(2 + 2 * PB);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
  typedef enum logic [1:0] {C_RATE, C_TRIG, C_RST} cmd_t;

  state_t            state, state_nx;
  cmd_t              cmd;
  logic              consumed;
  logic [IW-1:0]     byte_idx;
  logic [7:0]        xor_acc;
  logic [GW-1:0]     gap;

  logic [RB*8-1:0]   sh_rate;
  logic              sh_edge;
  logic [7:0]        sh_thr;
  logic [PLW-1:0]    sh_plen;
  logic [PB*8-1:0]   sh_pat;
  logic [PB*8-1:0]   sh_mask;

  logic accept, start, store, commit, err, tmo;
  logic [1:0] err_val;

  assign accept = rx_data_fresh && !consumed;
  // the accepted byte wins over a timeout landing on the same edge
  assign tmo    = (state != IDLE) && !accept && (gap == GW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and per-edge control strobes
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    store    = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    err_val  = 2'd0;
    case (state)
      IDLE: if (accept) begin
        if (rx_data == 8'h17 || rx_data == 8'h18) begin
          start    = 1'b1;
          state_nx = PAYLOAD;
        end else if (rx_data == 8'h1A) begin
          start    = 1'b1;
          state_nx = CHECK;
        end else begin
          err      = 1'b1;
          err_val  = 2'd2;
        end
      end
      PAYLOAD: if (accept) begin
        store = 1'b1;
        if (byte_idx == ((cmd == C_RATE) ? RATE_LAST : TRIG_LAST)) state_nx = CHECK;
      end
      CHECK: if (accept) begin
        if (rx_data == xor_acc) commit = 1'b1;
        else begin
          err     = 1'b1;
          err_val = 2'd1;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo) begin
      state_nx = IDLE;
      err      = 1'b1;
      err_val  = 2'd3;
    end
  end

  // one byte per high episode of rx_data_fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 consumed <= 1'b0;
    else if (accept)         consumed <= 1'b1;
    else if (!rx_data_fresh) consumed <= 1'b0;
  end

  // inter-byte gap counter, only runs inside a packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          gap <= '0;
    else if (accept || state == IDLE) gap <= '0;
    else                              gap <= gap + 1'b1;
  end

  // command latch, running checksum and shadow field capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd      <= C_RATE;
      byte_idx <= '0;
      xor_acc  <= '0;
      sh_rate  <= '0;
      sh_edge  <= 1'b0;
      sh_thr   <= '0;
      sh_plen  <= '0;
      sh_pat   <= '0;
      sh_mask  <= '0;
    end else if (start) begin
      cmd      <= (rx_data == 8'h17) ? C_RATE : (rx_data == 8'h18) ? C_TRIG : C_RST;
      byte_idx <= '0;
      xor_acc  <= rx_data;
    end else if (store) begin
      byte_idx <= byte_idx + 1'b1;
      xor_acc  <= xor_acc ^ rx_data;
      if (cmd == C_RATE) begin
        for (int i = 0; i < RB; i++)
          if (byte_idx == IW'(i)) sh_rate[i*8 +: 8] <= rx_data;
      end else begin
        if (byte_idx == IW'(0)) sh_edge <= rx_data[0];
        if (byte_idx == IW'(1)) sh_thr  <= rx_data;
        if (byte_idx == IW'(2))
          sh_plen <= (rx_data > 8'(PATTERN_W)) ? PLW'(PATTERN_W) : PLW'(rx_data);
        for (int i = 0; i < PB; i++) begin
          if (byte_idx == IW'(3 + i))      sh_pat[i*8 +: 8]  <= rx_data;
          if (byte_idx == IW'(3 + PB + i)) sh_mask[i*8 +: 8] <= rx_data;
        end
      end
    end
  end

  // committed configuration, loaded atomically on a good checksum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampling_rate <= RATE_W'(1);
      trigger_edge  <= 1'b0;
      threshold     <= 8'h80;
      pattern_len   <= '0;
      pattern       <= '0;
      pattern_mask  <= '0;
    end else if (commit) begin
      case (cmd)
        C_RATE: sampling_rate <= sh_rate[RATE_W-1:0];
        C_TRIG: begin
          trigger_edge <= sh_edge;
          threshold    <= sh_thr;
          pattern_len  <= sh_plen;
          pattern      <= sh_pat[PATTERN_W-1:0];
          pattern_mask <= sh_mask[PATTERN_W-1:0];
        end
        default: begin
          sampling_rate <= RATE_W'(1);
          trigger_edge  <= 1'b0;
          threshold     <= 8'h80;
          pattern_len   <= '0;
          pattern       <= '0;
          pattern_mask  <= '0;
        end
      endcase
    end
  end

  // status pulses, sticky error code and idle indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      configuration_valid <= 1'b1;
      cfg_update          <= 1'b0;
      cmd_error           <= 1'b0;
      err_code            <= 2'd0;
    end else begin
      configuration_valid <= (state_nx == IDLE);
      cfg_update          <= commit;
      cmd_error           <= err;
      if (err) err_code <= err_val;
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed scenarios plus randomized packet traffic, checked
// every cycle against a byte-queue reference model of the packet protocol.
module tb_cmd_parser;
  localparam int PW = 8, RW = 16, TO = 100;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_data_fresh = 1'b0;
  logic [RW-1:0] sampling_rate;
  logic trigger_edge;
  logic [7:0] threshold;
  logic [3:0] pattern_len;
  logic [PW-1:0] pattern, pattern_mask;
  logic configuration_valid, cfg_update, cmd_error;
  logic [1:0] err_code;

  cmd_parser #(.PATTERN_W(PW), .RATE_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_fresh(rx_data_fresh),
    .sampling_rate(sampling_rate), .trigger_edge(trigger_edge), .threshold(threshold),
    .pattern_len(pattern_len), .pattern(pattern), .pattern_mask(pattern_mask),
    .configuration_valid(configuration_valid), .cfg_update(cfg_update),
    .cmd_error(cmd_error), .err_code(err_code));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_upd = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] pkt[$];
  logic m_cons;
  int   m_gap;
  logic [RW-1:0] m_rate;
  logic m_edge, m_upd, m_err, m_valid;
  logic [7:0] m_thr, m_pat, m_mask;
  logic [3:0] m_plen;
  logic [1:0] m_code;

  function automatic int plen_of(input logic [7:0] c);
    case (c)
      8'h17:   return 2;
      8'h18:   return 5;
      8'h1A:   return 0;
      default: return -1;
    endcase
  endfunction

  task automatic m_reset();
    pkt.delete();
    m_cons = 0; m_gap = 0;
    m_rate = 1; m_edge = 0; m_thr = 8'h80; m_plen = 0; m_pat = 0; m_mask = 0;
    m_upd = 0; m_err = 0; m_code = 0; m_valid = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        logic acc;
        logic [7:0] x;
        acc = rx_data_fresh && !m_cons;
        if (acc) m_cons = 1; else if (!rx_data_fresh) m_cons = 0;
        m_upd = 0; m_err = 0;
        if (acc) begin
          m_gap = 0;
          if (pkt.size() == 0) begin
            if (plen_of(rx_data) >= 0) pkt.push_back(rx_data);
            else begin m_err = 1; m_code = 2; end
          end else begin
            pkt.push_back(rx_data);
            if (pkt.size() == plen_of(pkt[0]) + 2) begin
              x = 0;
              foreach (pkt[i]) x ^= pkt[i];
              if (x == 0) begin
                m_upd = 1;
                case (pkt[0])
                  8'h17: m_rate = {pkt[2], pkt[1]};
                  8'h18: begin
                    m_edge = pkt[1][0]; m_thr = pkt[2];
                    m_plen = (pkt[3] > PW) ? 4'(PW) : 4'(pkt[3]);
                    m_pat = pkt[4]; m_mask = pkt[5];
                  end
                  default: begin
                    m_rate = 1; m_edge = 0; m_thr = 8'h80; m_plen = 0; m_pat = 0; m_mask = 0;
                  end
                endcase
              end else begin m_err = 1; m_code = 1; end
              pkt.delete();
            end
          end
        end else if (pkt.size() != 0) begin
          m_gap++;
          if (m_gap == TO) begin m_err = 1; m_code = 3; pkt.delete(); end
        end
        m_valid = (pkt.size() == 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("rate", 32'(sampling_rate), 32'(m_rate));
      chk("edge", 32'(trigger_edge), 32'(m_edge));
      chk("thr", 32'(threshold), 32'(m_thr));
      chk("plen", 32'(pattern_len), 32'(m_plen));
      chk("pat", 32'(pattern), 32'(m_pat));
      chk("mask", 32'(pattern_mask), 32'(m_mask));
      chk("valid", 32'(configuration_valid), 32'(m_valid));
      chk("upd", 32'(cfg_update), 32'(m_upd));
      chk("err", 32'(cmd_error), 32'(m_err));
      chk("code", 32'(err_code), 32'(m_code));
      if (cfg_update) n_upd++;
      if (cmd_error) n_err++;
    end
  end

  // ---------------- stimulus ----------------
  // sp = clock edges from this byte's acceptance to the next possible one
  task automatic send(input logic [7:0] b, input int sp, input int hold = 1);
    rx_data = b; rx_data_fresh = 1'b1;
    repeat (hold) @(negedge clk);
    rx_data_fresh = 1'b0; rx_data = 8'($urandom);
    repeat (sp - 1) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] p[$]);
    foreach (p[i]) send(p[i], $urandom_range(2, 4), ($urandom_range(0, 7) == 0) ? 3 : 1);
  endtask

  initial begin
    int u0, e0;
    logic [7:0] p[$];
    repeat (3) @(negedge clk);
    chk("reset_rate", 32'(sampling_rate), 32'h1);
    chk("reset_thr", 32'(threshold), 32'h80);
    chk("reset_valid", 32'(configuration_valid), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // 1: rate
    u0 = n_upd; e0 = n_err;
    p = '{8'h17, 8'h34, 8'h12, 8'h31}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s1_rate", 32'(sampling_rate), 32'h1234);
    chk("s1_upd", n_upd - u0, 1);
    chk("s1_err", n_err - e0, 0);

    // 2: trigger
    p = '{8'h18, 8'h01, 8'h40, 8'h05, 8'hA5, 8'h0F, 8'hF6}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s2", {trigger_edge, threshold, pattern_len, pattern, pattern_mask},
        {1'b1, 8'h40, 4'd5, 8'hA5, 8'h0F});

    // 3: bad checksum then reset_cfg
    e0 = n_err;
    p = '{8'h18, 8'h01, 8'h40, 8'h05, 8'hA5, 8'h0F, 8'h00}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s3_code", 32'(err_code), 32'd1);
    chk("s3_err", n_err - e0, 1);
    chk("s3_keep", {pattern_len, pattern, pattern_mask}, {4'd5, 8'hA5, 8'h0F});
    p = '{8'h1A, 8'h1A}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s3_rst", {sampling_rate, trigger_edge, threshold, pattern_len, pattern},
        {16'h1, 1'b0, 8'h80, 4'd0, 8'h00});

    // 4: unknown command
    send(8'h55, 3);
    chk("s4_code", 32'(err_code), 32'd2);
    chk("s4_valid", 32'(configuration_valid), 32'd1);
    p = '{8'h17, 8'h34, 8'h12, 8'h31}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s4_rate", 32'(sampling_rate), 32'h1234);

    // 5a: stall past timeout
    e0 = n_err;
    send(8'h17, 2); send(8'h34, 110);
    chk("s5_code", 32'(err_code), 32'd3);
    chk("s5_err", n_err - e0, 1);
    chk("s5_valid", 32'(configuration_valid), 32'd1);
    chk("s5_rate", 32'(sampling_rate), 32'h1234);
    // 5b: late bytes at 99 and exactly 100 edges still extend the packet
    e0 = n_err;
    send(8'h17, 99); send(8'hEF, 2); send(8'hBE, 2); send(8'h46, 3);
    chk("s5_99", 32'(sampling_rate), 32'hBEEF);
    send(8'h17, 2); send(8'hCD, 100); send(8'hAB, 2); send(8'h71, 3);
    chk("s5_100", 32'(sampling_rate), 32'hABCD);
    chk("s5_noerr", n_err - e0, 0);

    // 6a: fresh held 10 cycles
    send(8'h17, 2, 10); send(8'h78, 2); send(8'h56, 2); send(8'h39, 3);
    chk("s6_hold", 32'(sampling_rate), 32'h5678);
    // 6b: pattern_len saturation
    p = '{8'h18, 8'h00, 8'h10, 8'h0C, 8'h3C, 8'hFF, 8'hC7}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s6_sat", 32'(pattern_len), 32'd8);
    // 6c: reset mid-packet
    send(8'h18, 2); send(8'h01, 2);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    chk("s6_rst", {sampling_rate, threshold, pattern_len, configuration_valid},
        {16'h1, 8'h80, 4'd0, 1'b1});
    p = '{8'h17, 8'h34, 8'h12, 8'h31}; send_pkt(p); repeat (3) @(negedge clk);
    chk("s6_idle", 32'(sampling_rate), 32'h1234);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [7:0] x;
      kind = $urandom_range(0, 5);
      p.delete();
      case (kind)
        0, 3: begin
          p.push_back(8'h17); p.push_back(8'($urandom)); p.push_back(8'($urandom));
        end
        1: begin
          p.push_back(8'h18); p.push_back(8'($urandom)); p.push_back(8'($urandom));
          p.push_back(8'($urandom_range(0, 15)));
          p.push_back(8'($urandom)); p.push_back(8'($urandom));
        end
        2: p.push_back(8'h1A);
        4: begin
          x = 8'($urandom);
          while (x == 8'h17 || x == 8'h18 || x == 8'h1A) x = 8'($urandom);
          p.push_back(x);
        end
        default: begin
          p.push_back(($urandom_range(0, 1) != 0) ? 8'h17 : 8'h18); p.push_back(8'($urandom));
        end
      endcase
      if (kind <= 3) begin
        x = 0;
        foreach (p[i]) x ^= p[i];
        if (kind == 3) x ^= 8'($urandom_range(1, 255));
        p.push_back(x);
      end
      send_pkt(p);
      if (kind == 5) repeat (TO + 5) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
